// File: rtl/ps2_key_decoder.sv
// PS/2 keyboard receiver: input conditioning, 11-bit frame checking, E0/F0 prefix folding,
// arrow-key level bitmap and a first-word fall-through event FIFO.
module ps2_key_decoder #(
    parameter int unsigned SYNC_STAGES    = 2,
    parameter int unsigned FILTER_LEN     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 56750,
    parameter int unsigned FIFO_DEPTH     = 4
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          ps2_clk,
    input  logic                          ps2_data,
    output logic                          ev_valid,
    input  logic                          ev_ready,
    output logic [7:0]                    ev_code,
    output logic                          ev_ext,
    output logic                          ev_brk,
    output logic [3:0]                    arrows,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          frame_err,
    output logic                          overflow
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
    localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

    typedef enum logic [1:0] {StIdle, StData, StParity, StStop} state_e;

    logic [SYNC_STAGES-1:0] clk_sync_q, data_sync_q;
    logic                   filt_q, filt_d;
    logic [FW-1:0]          flt_cnt_q, flt_cnt_d;
    state_e                 state_q, state_d;
    logic [7:0]             shift_q, shift_d;
    logic [2:0]             bit_cnt_q, bit_cnt_d;
    logic                   par_ok_q, par_ok_d;
    logic [TW-1:0]          tmo_q, tmo_d;
    logic                   byte_valid_q, byte_valid_d;
    logic                   frame_err_q, frame_err_d;
    logic                   ext_pend_q, ext_pend_d, brk_pend_q, brk_pend_d;
    logic [3:0]             arrows_q, arrows_d;
    logic [9:0]             mem_q [FIFO_DEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [9:0]             hold_q, hold_d, head;
    logic                   overflow_q, overflow_d;

    logic clk_s, data_s, strobe, timeout, emit, full, pop, push;
    logic [9:0] ev_data;

    assign clk_s   = clk_sync_q[SYNC_STAGES-1];
    assign data_s  = data_sync_q[SYNC_STAGES-1];
    assign strobe  = filt_q & ~filt_d;
    assign timeout = (state_q != StIdle) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
    assign emit    = byte_valid_q && (shift_q != 8'hE0) && (shift_q != 8'hF0);
    assign ev_data = {ext_pend_q, brk_pend_q, shift_q};
    assign full    = (count_q == (AW+1)'(FIFO_DEPTH));
    assign pop     = (count_q != '0) && ev_ready;
    assign push    = emit && (!full || pop);
    assign head    = (count_q != '0) ? mem_q[rd_ptr_q] : hold_q;

    always_comb begin
        filt_d       = filt_q;
        flt_cnt_d    = '0;
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        par_ok_d     = par_ok_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        tmo_d        = (state_q == StIdle || strobe) ? '0 : tmo_q + TW'(1);
        ext_pend_d   = ext_pend_q;
        brk_pend_d   = brk_pend_q;
        arrows_d     = arrows_q;

        // Filtered clock flips only after FILTER_LEN consecutive differing samples.
        if (clk_s != filt_q) begin
            if (flt_cnt_q == FW'(FILTER_LEN - 1)) filt_d = clk_s;
            else                                  flt_cnt_d = flt_cnt_q + FW'(1);
        end

        if (timeout) begin
            state_d     = StIdle;
            frame_err_d = 1'b1;
        end else if (strobe) begin
            case (state_q)
                StIdle: begin
                    if (!data_s) begin
                        state_d   = StData;
                        bit_cnt_d = 3'd0;
                    end
                end
                StData: begin
                    shift_d   = {data_s, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) state_d = StParity;
                end
                StParity: begin
                    par_ok_d = ^{shift_q, data_s};
                    state_d  = StStop;
                end
                default: begin
                    if (par_ok_q && data_s) byte_valid_d = 1'b1;
                    else                    frame_err_d  = 1'b1;
                    state_d = StIdle;
                end
            endcase
        end

        if (timeout) begin
            ext_pend_d = 1'b0;
            brk_pend_d = 1'b0;
        end else if (byte_valid_q) begin
            if (shift_q == 8'hE0)      ext_pend_d = 1'b1;
            else if (shift_q == 8'hF0) brk_pend_d = 1'b1;
            else begin
                ext_pend_d = 1'b0;
                brk_pend_d = 1'b0;
            end
        end

        // Bitmap tracks every extended event, including ones the FIFO drops.
        if (emit && ext_pend_q) begin
            case (shift_q)
                8'h75:   arrows_d[3] = ~brk_pend_q;
                8'h6B:   arrows_d[2] = ~brk_pend_q;
                8'h72:   arrows_d[1] = ~brk_pend_q;
                8'h74:   arrows_d[0] = ~brk_pend_q;
                default: arrows_d    = arrows_q;
            endcase
        end

        wr_ptr_d   = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d   = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
        hold_d     = pop ? mem_q[rd_ptr_q] : hold_q;
        overflow_d = emit && full && !pop;
        count_d    = count_q;
        if (push && !pop)      count_d = count_q + (AW+1)'(1);
        else if (pop && !push) count_d = count_q - (AW+1)'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            clk_sync_q   <= '1;
            data_sync_q  <= '1;
            filt_q       <= 1'b1;
            flt_cnt_q    <= '0;
            state_q      <= StIdle;
            shift_q      <= '0;
            bit_cnt_q    <= '0;
            par_ok_q     <= 1'b0;
            tmo_q        <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            ext_pend_q   <= 1'b0;
            brk_pend_q   <= 1'b0;
            arrows_q     <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_q       <= '0;
            overflow_q   <= 1'b0;
        end else begin
            clk_sync_q   <= {clk_sync_q[SYNC_STAGES-2:0], ps2_clk};
            data_sync_q  <= {data_sync_q[SYNC_STAGES-2:0], ps2_data};
            filt_q       <= filt_d;
            flt_cnt_q    <= flt_cnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            par_ok_q     <= par_ok_d;
            tmo_q        <= tmo_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            ext_pend_q   <= ext_pend_d;
            brk_pend_q   <= brk_pend_d;
            arrows_q     <= arrows_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            hold_q       <= hold_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= ev_data;
    end

    assign {ev_ext, ev_brk, ev_code} = head;
    assign ev_valid   = (count_q != '0);
    assign arrows     = arrows_q;
    assign fifo_level = count_q;
    assign frame_err  = frame_err_q;
    assign overflow   = overflow_q;

endmodule
